// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_bcd
//  Description : BCD stopwatch (MM:SS.CC, max 59:59.99). The 1 kHz divider
//                output is sampled as data. Each rising edge is one tick.
//                Start/stop, clear and saturating FULL state.
//                Optional display-hold (lap) feature: STOPWATCH_LAP_HOLD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_bcd #(
  parameter int TICKS_PER_CS = 10
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_1k,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       running,
  output logic       full,
  output logic       hold_active,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones
);

  localparam logic [3:0] c_PS_LAST = 4'(TICKS_PER_CS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_tick_q;
  logic [3:0] r_ps;
  logic       r_running;
  logic       r_full;
  logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones, r_cs_tens, r_cs_ones;

  logic w_tick_rise;
  logic w_at_max;

  assign w_tick_rise = tick_1k & ~r_tick_q;
  assign w_at_max    = (r_min_tens == 4'd5) && (r_min_ones == 4'd9) &&
                       (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9) &&
                       (r_cs_tens  == 4'd9) && (r_cs_ones  == 4'd9);

`ifdef STOPWATCH_LAP_HOLD_EN
  logic       r_hold;
  logic [3:0] r_snap_min_tens, r_snap_min_ones, r_snap_sec_tens;
  logic [3:0] r_snap_sec_ones, r_snap_cs_tens, r_snap_cs_ones;
`endif

  // Control FSM, prescaler, BCD ripple counter and (optionally) lap snapshot.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_q   <= 1'b0;
      r_ps       <= 4'd0;
      r_running  <= 1'b0;
      r_full     <= 1'b0;
      r_min_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
      r_cs_tens  <= 4'd0;
      r_cs_ones  <= 4'd0;
`ifdef STOPWATCH_LAP_HOLD_EN
      r_hold          <= 1'b0;
      r_snap_min_tens <= 4'd0;
      r_snap_min_ones <= 4'd0;
      r_snap_sec_tens <= 4'd0;
      r_snap_sec_ones <= 4'd0;
      r_snap_cs_tens  <= 4'd0;
      r_snap_cs_ones  <= 4'd0;
`endif
    end else begin
      r_tick_q <= tick_1k;
      if (clear) begin
        r_state    <= S_IDLE;
        r_ps       <= 4'd0;
        r_running  <= 1'b0;
        r_full     <= 1'b0;
        r_min_tens <= 4'd0;
        r_min_ones <= 4'd0;
        r_sec_tens <= 4'd0;
        r_sec_ones <= 4'd0;
        r_cs_tens  <= 4'd0;
        r_cs_ones  <= 4'd0;
`ifdef STOPWATCH_LAP_HOLD_EN
        r_hold     <= 1'b0;
`endif
      end else begin
`ifdef STOPWATCH_LAP_HOLD_EN
        // Lap toggles the hold; FULL entry below overrides it back to 0.
        if (lap && (r_state == S_RUN || r_state == S_PAUSE)) begin
          if (!r_hold) begin
            r_hold          <= 1'b1;
            r_snap_min_tens <= r_min_tens;
            r_snap_min_ones <= r_min_ones;
            r_snap_sec_tens <= r_sec_tens;
            r_snap_sec_ones <= r_sec_ones;
            r_snap_cs_tens  <= r_cs_tens;
            r_snap_cs_ones  <= r_cs_ones;
          end else begin
            r_hold <= 1'b0;
          end
        end
`endif
        case (r_state)
          S_IDLE, S_PAUSE: begin
            // A tick coinciding with the start pulse is not counted.
            if (start_stop) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          S_RUN: begin
            if (start_stop) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end
            // The tick in the stop cycle still counts: state is RUN now.
            if (w_tick_rise) begin
              if (r_ps == c_PS_LAST) begin
                r_ps <= 4'd0;
                if (w_at_max) begin
                  r_state   <= S_FULL;
                  r_running <= 1'b0;
                  r_full    <= 1'b1;
`ifdef STOPWATCH_LAP_HOLD_EN
                  r_hold    <= 1'b0;
`endif
                end else if (r_cs_ones != 4'd9) begin
                  r_cs_ones <= r_cs_ones + 4'd1;
                end else begin
                  r_cs_ones <= 4'd0;
                  if (r_cs_tens != 4'd9) begin
                    r_cs_tens <= r_cs_tens + 4'd1;
                  end else begin
                    r_cs_tens <= 4'd0;
                    if (r_sec_ones != 4'd9) begin
                      r_sec_ones <= r_sec_ones + 4'd1;
                    end else begin
                      r_sec_ones <= 4'd0;
                      if (r_sec_tens != 4'd5) begin
                        r_sec_tens <= r_sec_tens + 4'd1;
                      end else begin
                        r_sec_tens <= 4'd0;
                        if (r_min_ones != 4'd9) begin
                          r_min_ones <= r_min_ones + 4'd1;
                        end else begin
                          // min_tens never passes 5: 59:59.99 saturates.
                          r_min_ones <= 4'd0;
                          r_min_tens <= r_min_tens + 4'd1;
                        end
                      end
                    end
                  end
                end
              end else begin
                r_ps <= r_ps + 4'd1;
              end
            end
          end
          default: begin
            // FULL: only clear or rst leave this state.
          end
        endcase
      end
    end
  end

  assign running = r_running;
  assign full    = r_full;

`ifdef STOPWATCH_LAP_HOLD_EN
  // Display mux: frozen snapshot while hold is active, live digits otherwise.
  assign hold_active = r_hold;
  assign min_tens    = r_hold ? r_snap_min_tens : r_min_tens;
  assign min_ones    = r_hold ? r_snap_min_ones : r_min_ones;
  assign sec_tens    = r_hold ? r_snap_sec_tens : r_sec_tens;
  assign sec_ones    = r_hold ? r_snap_sec_ones : r_sec_ones;
  assign cs_tens     = r_hold ? r_snap_cs_tens  : r_cs_tens;
  assign cs_ones     = r_hold ? r_snap_cs_ones  : r_cs_ones;
`else
  // Lap is ignored in this build; digits are always live.
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign hold_active  = 1'b0;
  assign min_tens     = r_min_tens;
  assign min_ones     = r_min_ones;
  assign sec_tens     = r_sec_tens;
  assign sec_ones     = r_sec_ones;
  assign cs_tens      = r_cs_tens;
  assign cs_ones      = r_cs_ones;
`endif

endmodule
`default_nettype wire
